// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side SRAM-like to AXI single-beat read bridge, in-order returns.
// Optional registered return path: define INST_BRIDGE_RDATA_REG_EN.
module inst_axi_rd_bridge #(
   parameter int         MAX_OUTST = 2,
   parameter logic [3:0] AXI_ID    = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_BUSY = 1'b1;
   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

   logic [0:0]  ar_state;
   logic [1:0]  outst_cnt;
   logic [31:0] araddr_q;
   logic [1:0]  arsize_q;
   logic        accept;
   logic        r_fire;
   logic        ret;

   // Write-side and response-status inputs have no effect on a read-only port.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                            rid, rresp, rlast};

   assign accept = inst_sram_req && inst_sram_addr_ok;
   assign inst_sram_addr_ok = !reset && (ar_state == AR_IDLE) &&
                              inst_sram_req && (outst_cnt < MAX_CNT);
   assign r_fire = rvalid && rready;

   assign arid    = AXI_ID;
   assign araddr  = araddr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, arsize_q};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = (ar_state == AR_BUSY);

`ifdef INST_BRIDGE_RDATA_REG_EN
   logic        data_ok_q;
   logic [31:0] rdata_q;

   // A registered beat still counts as outstanding until data_ok_q retires it.
   assign rready = !reset &&
                   ((outst_cnt - {1'b0, data_ok_q}) != 2'd0);
   assign ret = data_ok_q;
   assign inst_sram_data_ok = data_ok_q;
   assign inst_sram_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_ok_q <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         data_ok_q <= r_fire;
         if (r_fire) rdata_q <= rdata;
      end
   end
`else
   assign rready = !reset && (outst_cnt != 2'd0);
   assign ret = r_fire;
   assign inst_sram_data_ok = r_fire;
   assign inst_sram_rdata = rdata;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ar_state  <= AR_IDLE;
         outst_cnt <= 2'd0;
         araddr_q  <= 32'd0;
         arsize_q  <= 2'd0;
      end else begin
         outst_cnt <= outst_cnt + {1'b0, accept} - {1'b0, ret};
         case (ar_state)
            AR_IDLE: begin
               if (accept) begin
                  araddr_q <= inst_sram_addr;
                  arsize_q <= inst_sram_size;
                  ar_state <= AR_BUSY;
               end
            end
            AR_BUSY: begin
               if (arready) ar_state <= AR_IDLE;
            end
            default: ar_state <= AR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge (default zero-latency return path).
module tb_inst_axi_rd_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   inst_axi_rd_bridge #(.MAX_OUTST(2), .AXI_ID(4'h0)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache),
      .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      inst_sram_req = 1'b0;
      inst_sram_wr = 1'b0;
      inst_sram_size = 2'd0;
      inst_sram_wstrb = 4'd0;
      inst_sram_addr = 32'd0;
      inst_sram_wdata = 32'd0;
      arready = 1'b0;
      rid = 4'd0;
      rdata = 32'd0;
      rresp = 2'd0;
      rlast = 1'b1;
      rvalid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_addr_ok", inst_sram_addr_ok, 0);
      chk("rst_data_ok", inst_sram_data_ok, 0);
      chk("rst_rdata", inst_sram_rdata, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arsize", arsize, 0);
      chk("rst_cnt", dut.outst_cnt, 0);

      // single read
      tick();
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1c00_0000;
      inst_sram_size = 2'd2;
      #1;
      chk("s_addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      #1;
      chk("s_arvalid", arvalid, 1);
      chk("s_araddr", araddr, 32'h1c00_0000);
      chk("s_arsize", arsize, 2);
      chk("s_arlen", arlen, 0);
      chk("s_arburst", arburst, 1);
      chk("s_arid", arid, 0);
      chk("s_busy_addr_ok", inst_sram_addr_ok, 0);
      chk("s_rready", rready, 1);
      tick();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata = 32'h0280_0c0c;
      #1;
      chk("s_arvalid_drop", arvalid, 0);
      chk("s_data_ok", inst_sram_data_ok, 1);
      chk("s_rdata", inst_sram_rdata, 32'h0280_0c0c);
      tick();
      rvalid = 1'b0;
      #1;
      chk("s_cnt0", dut.outst_cnt, 0);
      chk("s_data_ok_low", inst_sram_data_ok, 0);

      // pipelined requests, R held off
      tick();
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1c00_0000;
      arready = 1'b1;
      #1;
      chk("p0_addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_addr = 32'h1c00_0004;
      #1;
      chk("p1_busy_addr_ok", inst_sram_addr_ok, 0);
      chk("p1_araddr", araddr, 32'h1c00_0000);
      tick();
      #1;
      chk("p2_addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_addr = 32'h1c00_0008;
      #1;
      chk("p3_araddr", araddr, 32'h1c00_0004);
      chk("p3_addr_ok", inst_sram_addr_ok, 0);
      tick();
      #1;
      chk("p4_limit_addr_ok", inst_sram_addr_ok, 0);
      chk("p4_cnt2", dut.outst_cnt, 2);
      chk("p4_arvalid", arvalid, 0);
      tick();
      rvalid = 1'b1;
      rdata = 32'haaaa_0000;
      #1;
      chk("p5_data_ok", inst_sram_data_ok, 1);
      chk("p5_rdata", inst_sram_rdata, 32'haaaa_0000);
      chk("p5_addr_ok", inst_sram_addr_ok, 0);
      tick();
      rdata = 32'haaaa_0004;
      #1;
      chk("p6_addr_ok", inst_sram_addr_ok, 1);
      chk("p6_data_ok", inst_sram_data_ok, 1);
      chk("p6_rdata", inst_sram_rdata, 32'haaaa_0004);
      chk("p6_cnt1", dut.outst_cnt, 1);
      tick();
      inst_sram_req = 1'b0;
      rvalid = 1'b0;
      #1;
      chk("p7_cnt_same", dut.outst_cnt, 1);
      chk("p7_araddr", araddr, 32'h1c00_0008);
      chk("p7_arvalid", arvalid, 1);
      tick();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata = 32'haaaa_0008;
      #1;
      chk("p8_data_ok", inst_sram_data_ok, 1);
      chk("p8_rdata", inst_sram_rdata, 32'haaaa_0008);
      tick();
      rvalid = 1'b0;
      #1;
      chk("p9_cnt0", dut.outst_cnt, 0);

      // AR backpressure, error response still returned
      tick();
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1c00_0010;
      #1;
      chk("b_addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_addr = 32'h1c00_0014;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         #1;
         chk("b_hold_arvalid", arvalid, 1);
         chk("b_hold_araddr", araddr, 32'h1c00_0010);
         chk("b_hold_addr_ok", inst_sram_addr_ok, 0);
      end
      tick();
      arready = 1'b1;
      #1;
      chk("b6_arvalid", arvalid, 1);
      chk("b6_araddr", araddr, 32'h1c00_0010);
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b0;
      rvalid = 1'b1;
      rresp = 2'b10;
      rdata = 32'h1234_5678;
      #1;
      chk("b_arvalid_drop", arvalid, 0);
      chk("e_data_ok", inst_sram_data_ok, 1);
      chk("e_rdata", inst_sram_rdata, 32'h1234_5678);
      tick();
      rvalid = 1'b0;
      rresp = 2'b00;
      #1;
      chk("e_cnt0", dut.outst_cnt, 0);

      // spurious beat with nothing outstanding
      tick();
      rvalid = 1'b1;
      rdata = 32'hdead_beef;
      #1;
      chk("sp_rready", rready, 0);
      chk("sp_data_ok", inst_sram_data_ok, 0);
      tick();
      rvalid = 1'b0;
      #1;
      chk("sp_cnt0", dut.outst_cnt, 0);

      // reset while busy with two outstanding
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1c00_0020;
      #1;
      chk("r0_addr_ok", inst_sram_addr_ok, 1);
      tick();
      arready = 1'b1;
      inst_sram_addr = 32'h1c00_0024;
      tick();
      #1;
      chk("r2_addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b0;
      #1;
      chk("r3_arvalid", arvalid, 1);
      chk("r3_cnt2", dut.outst_cnt, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("r4_arvalid", arvalid, 0);
      chk("r4_rready", rready, 0);
      chk("r4_cnt0", dut.outst_cnt, 0);
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1c00_0030;
      #1;
      chk("r4_addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      #1;
      chk("r5_araddr", araddr, 32'h1c00_0030);
      chk("r5_cnt1", dut.outst_cnt, 1);
      tick();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata = 32'h0000_0013;
      #1;
      chk("r6_data_ok", inst_sram_data_ok, 1);
      chk("r6_rdata", inst_sram_rdata, 32'h0000_0013);
      tick();
      rvalid = 1'b0;
      #1;
      chk("r7_cnt0", dut.outst_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
